// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard scheduler for the 5-stage core.
//
// Drives the enable/clear controls of PC, IF/ID, ID/EX and EX/MEM and the EX
// operand forwarding selects. Three hazards are handled:
//   * taken branch resolved in EX : flush IF/ID and bubble ID/EX
//   * multi-cycle EX op           : freeze the whole front end plus EX/MEM
//   * data dependence in ID       : hold PC and IF/ID, bubble ID/EX
//
// Build option (macro FORWARDING_EN):
//   defined   : EX forwarding active; only a load in EX feeding ID stalls.
//   undefined : no forwarding (fwdA/fwdB tied 00); any ID source matching a
//               pending write in EX or MEM stalls (RAW stall).
//
// Parameters:
//   MUL_LAT  total EX cycles of a multi-cycle op (>= 2)
//   NREG_W   register-index width
//
// Ports:
//   reloj, reset                 clock (rising edge), async active-low reset
//   id_valid, id_rs, id_rt,
//   id_uses_rt                   instruction in ID and its source registers
//   ex_rs, ex_rt, ex_rd,
//   ex_regwrite, ex_memread      instruction in EX
//   ex_mult_start                1-cycle pulse: multi-cycle op entered EX
//   branch_taken                 EX resolved a taken branch/jump
//   mem_rd, mem_regwrite         destination of instruction in MEM
//   wb_rd, wb_regwrite           destination of instruction in WB
//   enablePC, enableIFID,
//   enableID, enableEX           pipeline register load enables
//   flushIFID, resetID           IF/ID clear, ID/EX bubble (active-high)
//   fwdA, fwdB                   EX operand select: 00 regfile,
//                                01 EX/MEM result, 10 MEM/WB result
//   busy                         multi-cycle op still waiting for its result
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int NREG_W  = 5
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [NREG_W-1:0] ex_rs,
    input  logic [NREG_W-1:0] ex_rt,
    input  logic [NREG_W-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_mult_start,
    input  logic              branch_taken,
    input  logic [NREG_W-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [NREG_W-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic              enablePC,
    output logic              enableIFID,
    output logic              flushIFID,
    output logic              enableID,
    output logic              resetID,
    output logic              enableEX,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB,
    output logic              busy
);

    // Down-counter covers MUL_LAT-2 .. 0; keep at least one bit for MUL_LAT=2.
    localparam int              CNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // A producer only counts if it really writes and is not r0.
    function automatic logic reg_match(input logic              wr,
                                       input logic [NREG_W-1:0] rd,
                                       input logic [NREG_W-1:0] src);
        return wr && (rd != '0) && (rd == src);
    endfunction

    // ID source dependence on the destination of the instruction in EX.
    logic id_dep_ex;
    assign id_dep_ex = reg_match(1'b1, ex_rd, id_rs) ||
                       (id_uses_rt && reg_match(1'b1, ex_rd, id_rt));

    logic       stall_req;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

`ifdef FORWARDING_EN
    // EX/MEM (instruction now in MEM) is younger, so it beats MEM/WB.
    function automatic logic [1:0] fwd_pick(input logic [NREG_W-1:0] src,
                                            input logic              m_wr,
                                            input logic [NREG_W-1:0] m_rd,
                                            input logic              w_wr,
                                            input logic [NREG_W-1:0] w_rd);
        if (reg_match(m_wr, m_rd, src))
            return 2'b01;
        else if (reg_match(w_wr, w_rd, src))
            return 2'b10;
        return 2'b00;
    endfunction

    // With forwarding only a load result is too late for the next op.
    assign stall_req = id_valid && ex_memread && id_dep_ex;
    assign fwd_a_sel = fwd_pick(ex_rs, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
    assign fwd_b_sel = fwd_pick(ex_rt, mem_regwrite, mem_rd, wb_regwrite, wb_rd);

    logic unused_nofwd_inputs;
    assign unused_nofwd_inputs = ex_regwrite;
`else
    // Without forwarding a value is usable only once it reaches WB (the
    // regfile writes first half / reads second half), so producers in EX
    // and MEM both stall. The producer walks EX->MEM, giving up to 2 bubbles.
    logic id_dep_mem;
    assign id_dep_mem = reg_match(1'b1, mem_rd, id_rs) ||
                        (id_uses_rt && reg_match(1'b1, mem_rd, id_rt));

    assign stall_req = id_valid && ((ex_regwrite && id_dep_ex) ||
                                    (mem_regwrite && id_dep_mem));
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite, ex_memread};
`endif

    // Multi-cycle sequencing. A taken branch outranks a multiply start,
    // and nothing interrupts MULT_WAIT except reset.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!branch_taken && ex_mult_start) begin
                        cnt   <= CNT_LOAD;
                        state <= MULT_WAIT;
                    end
                end
                MULT_WAIT: begin
                    if (cnt == '0)
                        state <= RUN;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Control outputs are Mealy so a hazard acts at the edge it is seen.
    // Reset is folded in combinationally so a reset mid-freeze releases
    // the outputs without waiting for a clock.
    always_comb begin
        enablePC   = 1'b1;
        enableIFID = 1'b1;
        flushIFID  = 1'b0;
        enableID   = 1'b1;
        resetID    = 1'b0;
        enableEX   = 1'b1;
        fwdA       = fwd_a_sel;
        fwdB       = fwd_b_sel;
        busy       = 1'b0;

        if (!reset) begin
            enablePC   = 1'b0;
            enableIFID = 1'b0;
            flushIFID  = 1'b1;
            enableID   = 1'b0;
            resetID    = 1'b1;
            enableEX   = 1'b0;
            fwdA       = 2'b00;
            fwdB       = 2'b00;
        end else if (state == MULT_WAIT) begin
            enablePC   = 1'b0;
            enableIFID = 1'b0;
            enableID   = 1'b0;
            // Last wait cycle releases the result into EX/MEM; busy covers
            // only the cycles where the result is still outstanding.
            enableEX   = (cnt == '0);
            busy       = (cnt != '0);
        end else if (branch_taken) begin
            flushIFID  = 1'b1;
            resetID    = 1'b1;
        end else if (ex_mult_start) begin
            enablePC   = 1'b0;
            enableIFID = 1'b0;
            enableID   = 1'b0;
            enableEX   = 1'b0;
        end else if (stall_req) begin
            // Hold PC and IF/ID, load a bubble into ID/EX.
            enablePC   = 1'b0;
            enableIFID = 1'b0;
            resetID    = 1'b1;
        end
    end

endmodule
